// File: rtl/cordic_angle_sequencer.sv
// Range-reducing front end for a CORDIC rotator: folds a Q3.16 angle into [-pi/2, pi/2],
// runs one CORDIC operation, then sign-corrects cos/sin. Optional watchdog: CORDIC_SEQ_TIMEOUT_EN.
module cordic_angle_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [18:0] in_angle,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [17:0] cordic_angle,
    output logic               cordic_init,
    input  logic signed [17:0] cordic_cos,
    input  logic signed [17:0] cordic_sin,
    input  logic               cordic_done,
    output logic signed [17:0] out_cos,
    output logic signed [17:0] out_sin,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RED1  = 3'd1,
        S_RED2  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic signed [19:0] PI     = 20'sd205887;
    localparam logic signed [19:0] PI_2   = 20'sd102944;
    localparam logic signed [19:0] TWO_PI = 20'sd411775;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    end

    // Negation saturates at the most negative code so the result stays representable.
    function automatic logic signed [17:0] sat_neg(input logic signed [17:0] x);
        return (x == 18'sh20000) ? 18'sh1FFFF : -x;
    endfunction

    state_t             state_q, state_d;
    logic signed [19:0] angle_q, angle_d;
    logic               neg_q, neg_d;
    logic signed [17:0] cordic_angle_q, cordic_angle_d;
    logic               cordic_init_q, cordic_init_d;
    logic signed [17:0] out_cos_q, out_cos_d;
    logic signed [17:0] out_sin_q, out_sin_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               wait_first_q, wait_first_d;
    logic               accept_s;
    logic               done_ok_s;
    logic               timeout_s;

`ifdef CORDIC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             out_err_q, out_err_d;
`endif

    assign accept_s  = (state_q == S_IDLE) && in_valid && in_ready_q;
    // The first WAIT cycle may still see done from the previous operation.
    assign done_ok_s = (state_q == S_WAIT) && !wait_first_q && cordic_done;
`ifdef CORDIC_SEQ_TIMEOUT_EN
    assign timeout_s = (state_q == S_WAIT) && !done_ok_s && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            angle_q        <= 20'sd0;
            neg_q          <= 1'b0;
            cordic_angle_q <= 18'sd0;
            cordic_init_q  <= 1'b0;
            out_cos_q      <= 18'sd0;
            out_sin_q      <= 18'sd0;
            out_valid_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            wait_first_q   <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            wait_cnt_q     <= '0;
            out_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            angle_q        <= angle_d;
            neg_q          <= neg_d;
            cordic_angle_q <= cordic_angle_d;
            cordic_init_q  <= cordic_init_d;
            out_cos_q      <= out_cos_d;
            out_sin_q      <= out_sin_d;
            out_valid_q    <= out_valid_d;
            in_ready_q     <= in_ready_d;
            wait_first_q   <= wait_first_d;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            out_err_q      <= out_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept_s ? S_RED1 : S_IDLE;
            S_RED1:  state_d = S_RED2;
            S_RED2:  state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  state_d = (done_ok_s || timeout_s) ? S_OUT : S_WAIT;
            S_OUT:   state_d = (out_valid_q && out_ready) ? S_IDLE : S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        angle_d        = angle_q;
        neg_d          = neg_q;
        cordic_angle_d = cordic_angle_q;
        out_cos_d      = out_cos_q;
        out_sin_d      = out_sin_q;
`ifdef CORDIC_SEQ_TIMEOUT_EN
        wait_cnt_d     = (state_q == S_WAIT) ? wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        out_err_d      = out_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    angle_d = {in_angle[18], in_angle};
                    neg_d   = 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
                    out_err_d = 1'b0;
`endif
                end else begin
                    angle_d = angle_q;
                end
            end
            S_RED1: begin
                angle_d = (angle_q > PI)  ? angle_q - TWO_PI :
                          (angle_q < -PI) ? angle_q + TWO_PI : angle_q;
            end
            S_RED2: begin
                // Folding by pi flips the sign of both sin and cos.
                if (angle_q > PI_2) begin
                    angle_d = angle_q - PI;
                    neg_d   = 1'b1;
                end else if (angle_q < -PI_2) begin
                    angle_d = angle_q + PI;
                    neg_d   = 1'b1;
                end else begin
                    neg_d   = 1'b0;
                end
                cordic_angle_d = angle_d[17:0];
            end
            S_WAIT: begin
                if (done_ok_s) begin
                    out_cos_d = neg_q ? sat_neg(cordic_cos) : cordic_cos;
                    out_sin_d = neg_q ? sat_neg(cordic_sin) : cordic_sin;
`ifdef CORDIC_SEQ_TIMEOUT_EN
                    out_err_d = 1'b0;
`endif
                end else if (timeout_s) begin
                    out_cos_d = 18'sd0;
                    out_sin_d = 18'sd0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
                    out_err_d = 1'b1;
`endif
                end else begin
                    out_cos_d = out_cos_q;
                end
            end
            default: begin
                angle_d = angle_q;
            end
        endcase
        cordic_init_d = (state_d == S_START);
        out_valid_d   = (state_d == S_OUT);
        in_ready_d    = (state_d == S_IDLE);
        wait_first_d  = (state_d == S_WAIT) && (state_q != S_WAIT);
    end

    assign in_ready     = in_ready_q;
    assign cordic_angle = cordic_angle_q;
    assign cordic_init  = cordic_init_q;
    assign out_cos      = out_cos_q;
    assign out_sin      = out_sin_q;
    assign out_valid    = out_valid_q;
`ifdef CORDIC_SEQ_TIMEOUT_EN
    assign out_err      = out_err_q;
`else
    assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed bench for cordic_angle_sequencer; the bench plays the CORDIC with hand-computed results.
module tb_cordic_angle_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [18:0] in_angle;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] cordic_angle;
    logic               cordic_init;
    logic signed [17:0] cordic_cos;
    logic signed [17:0] cordic_sin;
    logic               cordic_done;
    logic signed [17:0] out_cos;
    logic signed [17:0] out_sin;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    int errors = 0;
    int checks = 0;

    cordic_angle_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .in_angle(in_angle), .in_valid(in_valid), .in_ready(in_ready),
        .cordic_angle(cordic_angle), .cordic_init(cordic_init),
        .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .cordic_done(cordic_done),
        .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept an angle and advance to the first WAIT cycle, checking the start sequence.
    task automatic start_op(input string name, input logic signed [18:0] a, input logic signed [17:0] exp_ca);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_timeout in_ready=%b exp=1", name, in_ready); end
        in_angle = a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s busy_ready got=%b exp=0", name, in_ready); end
        step();
        step();
        checks++; if (cordic_init !== 1'b1) begin errors++; $display("FAIL %s init_cycle3 got=%b exp=1", name, cordic_init); end
        checks++; if (cordic_angle !== exp_ca) begin errors++; $display("FAIL %s cordic_angle got=%0d exp=%0d", name, cordic_angle, exp_ca); end
        step();
        checks++; if (cordic_init !== 1'b0 || cordic_angle !== exp_ca) begin
            errors++; $display("FAIL %s wait_init_angle init=%b angle=%0d exp init=0 angle=%0d", name, cordic_init, cordic_angle, exp_ca);
        end
    endtask

    // Complete one full operation; optional stale done in WAIT cycle 1 and output back-pressure.
    task automatic run_op(input string name, input logic signed [18:0] a, input logic signed [17:0] exp_ca,
                          input logic signed [17:0] c_in, input logic signed [17:0] s_in,
                          input logic signed [17:0] exp_c, input logic signed [17:0] exp_s,
                          input bit stale, input int hold);
        start_op(name, a, exp_ca);
        if (stale) begin
            cordic_done = 1'b1;
            cordic_cos  = 18'sd12345;
            cordic_sin  = 18'sd54321;
        end
        step();
        cordic_done = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s stale_done out_valid=%b exp=0", name, out_valid); end
        step();
        cordic_cos  = c_in;
        cordic_sin  = s_in;
        cordic_done = 1'b1;
        step();
        cordic_done = 1'b0;
        cordic_cos  = 18'sd0;
        cordic_sin  = 18'sd0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got=%b exp=1", name, out_valid); end
        checks++; if (out_cos !== exp_c) begin errors++; $display("FAIL %s out_cos got=%0d exp=%0d", name, out_cos, exp_c); end
        checks++; if (out_sin !== exp_s) begin errors++; $display("FAIL %s out_sin got=%0d exp=%0d", name, out_sin, exp_s); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL %s out_err got=%b exp=0", name, out_err); end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            checks++; if (out_valid !== 1'b1 || out_cos !== exp_c || out_sin !== exp_s || in_ready !== 1'b0) begin
                errors++; $display("FAIL %s hold%0d valid=%b cos=%0d sin=%0d rdy=%b exp 1/%0d/%0d/0", name, i, out_valid, out_cos, out_sin, in_ready, exp_c, exp_s);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s handshake valid=%b rdy=%b exp 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_angle = 19'sd0; in_valid = 1'b0; out_ready = 1'b0;
        cordic_cos = 18'sd0; cordic_sin = 18'sd0; cordic_done = 1'b0;
        step();
        checks++; if (in_ready !== 1'b0 || cordic_init !== 1'b0 || cordic_angle !== 18'sd0 || out_cos !== 18'sd0 ||
                      out_sin !== 18'sd0 || out_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_state rdy=%b init=%b ang=%0d cos=%0d sin=%0d err=%b vld=%b exp all 0",
                               in_ready, cordic_init, cordic_angle, out_cos, out_sin, out_err, out_valid);
        end
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        run_op("zero", 19'sd0, 18'sd0, 18'sd65536, 18'sd0, 18'sd65536, 18'sd0, 1'b0, 0);
        run_op("pi", 19'sd205887, 18'sd0, 18'sd65536, 18'sd0, -18'sd65536, 18'sd0, 1'b0, 0);
        run_op("p3_5", 19'sd229376, 18'sd23488, 18'sd61374, 18'sd22990, -18'sd61374, -18'sd22990, 1'b0, 0);
        run_op("m3_5", -19'sd229376, -18'sd23488, 18'sd61374, -18'sd22990, -18'sd61374, 18'sd22990, 1'b0, 0);
    endtask

    task automatic test_hold();
        run_op("hold", -19'sd22647, -18'sd22647, 18'sd61662, -18'sd22200, 18'sd61662, -18'sd22200, 1'b0, 5);
    endtask

    task automatic test_stale_done();
        run_op("stale", 19'sd0, 18'sd0, 18'sd65536, 18'sd0, 18'sd65536, 18'sd0, 1'b1, 0);
    endtask

    task automatic test_boundaries();
        run_op("pi_2", 19'sd102944, 18'sd102944, 18'sd1, 18'sd65536, 18'sd1, 18'sd65536, 1'b0, 0);
        run_op("pi_2p1", 19'sd102945, -18'sd102942, 18'sd2, -18'sd65536, -18'sd2, 18'sd65536, 1'b0, 0);
        run_op("pi_p1", 19'sd205888, 18'sd0, 18'sd65536, 18'sd0, -18'sd65536, 18'sd0, 1'b0, 0);
        run_op("neg_pi", -19'sd205887, 18'sd0, 18'sd65536, 18'sd3, -18'sd65536, -18'sd3, 1'b0, 0);
        run_op("max", 19'sd262143, 18'sd56255, 18'sd100, 18'sd200, -18'sd100, -18'sd200, 1'b0, 0);
        run_op("min", -19'sd262144, -18'sd56256, 18'sd300, -18'sd400, -18'sd300, 18'sd400, 1'b0, 0);
        run_op("sat", 19'sd205887, 18'sd0, 18'sh20000, 18'sd131071, 18'sd131071, -18'sd131071, 1'b0, 0);
    endtask

    task automatic test_reset_mid_wait();
        start_op("rstwait", 19'sd229376, 18'sd23488);
        step();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || cordic_angle !== 18'sd0 || cordic_init !== 1'b0 || out_valid !== 1'b0 ||
                      out_cos !== 18'sd0 || out_sin !== 18'sd0 || out_err !== 1'b0) begin
            errors++; $display("FAIL rstwait_outputs rdy=%b ang=%0d init=%b vld=%b cos=%0d sin=%0d err=%b exp all 0",
                               in_ready, cordic_angle, cordic_init, out_valid, out_cos, out_sin, out_err);
        end
        cordic_done = 1'b1; cordic_cos = 18'sd777; cordic_sin = 18'sd888;
        step();
        rst = 1'b0;
        step();
        step();
        cordic_done = 1'b0; cordic_cos = 18'sd0; cordic_sin = 18'sd0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cos !== 18'sd0) begin
            errors++; $display("FAIL rstwait_late_done vld=%b rdy=%b cos=%0d exp 0/1/0", out_valid, in_ready, out_cos);
        end
    endtask

    task automatic test_no_done();
        start_op("nodone", 19'sd0, 18'sd0);
        for (int i = 0; i < 63; i++) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nodone_early vld=%b exp=0", out_valid); end
        step();
`ifdef CORDIC_SEQ_TIMEOUT_EN
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_cos !== 18'sd0 || out_sin !== 18'sd0) begin
            errors++; $display("FAIL timeout vld=%b err=%b cos=%0d sin=%0d exp 1/1/0/0", out_valid, out_err, out_cos, out_sin);
        end
`else
        for (int i = 0; i < 20; i++) step();
        checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin
            errors++; $display("FAIL no_watchdog vld=%b err=%b exp 0/0", out_valid, out_err);
        end
        cordic_cos = 18'sd65536; cordic_sin = 18'sd0; cordic_done = 1'b1;
        step();
        cordic_done = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_cos !== 18'sd65536) begin
            errors++; $display("FAIL late_done vld=%b cos=%0d exp 1/65536", out_valid, out_cos);
        end
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL nodone_exit rdy=%b vld=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_stale_done();
        test_boundaries();
        test_reset_mid_wait();
        test_no_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
